// File: rtl/dmem_trace_pkg.sv
// Shared types for the data-memory trace buffer: record layout and drain states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_trace_pkg;

  // One captured transaction. The field order sets the packed layout.
  localparam int REC_W = 98;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        read;
    logic        write;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } drain_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; storage is not reset, pointers and count are.
// Latency: a push is visible at the head one cycle after its edge; count updates on that edge.
// Backpressure: a push while full is ignored unless a pop occurs on the same edge.
//
// Ports:
//   clk, rst_n             clock, async active-low reset (shared with parent)
//   push, push_dat         write request and record
//   pop                    remove head (ignored while empty)
//   head_dat               current head record (valid while !empty)
//   full, empty, count     occupancy; count carries one extra bit so full != empty
module trace_fifo
  import dmem_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  trace_rec_t             push_dat,
  input  logic                   pop,
  output trace_rec_t             head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count says non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/dmem_trace_buffer.sv
// Captures every CPU data-memory access into a FIFO and replays each as a stable record plus an isolated strobe.
// Latency: capture in cycle 0 -> out_* valid in cycle 2, out_pulse high in cycle 3; one record per 3 cycles.
// Backpressure: none toward the CPU; captures arriving while full (and no pop) are dropped and counted.
//
// Ports:
//   clk, reset                          clock, async active-low reset
//   cap_addr/wdata/rdata/read/write     transaction observed this cycle (captured if read|write)
//   clear                               zero overflow and drop_cnt
//   out_addr/wdata/rdata/read/write     replayed record, held between loads
//   out_pulse                           one-cycle strobe; rising edge marks the record valid
//   count                               FIFO occupancy
//   overflow, drop_cnt                  sticky drop flag and saturating drop counter
module dmem_trace_buffer
  import dmem_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            cap_addr,
  input  logic [31:0]            cap_wdata,
  input  logic [31:0]            cap_rdata,
  input  logic                   cap_read,
  input  logic                   cap_write,
  input  logic                   clear,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_wdata,
  output logic [31:0]            out_rdata,
  output logic                   out_read,
  output logic                   out_write,
  output logic                   out_pulse,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  trace_rec_t       cap_rec, head_rec;
  trace_rec_t       out_rec_q, out_rec_d;
  drain_state_e     state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             cap_vld, fifo_full, fifo_empty;
  logic             pop, push_ok, drop;

  // Both flags high is a legal (if odd) record and is kept verbatim.
  assign cap_vld = cap_read | cap_write;
  assign cap_rec = '{addr: cap_addr, wdata: cap_wdata, rdata: cap_rdata,
                     read: cap_read, write: cap_write};

  // Records are loaded only from IDLE or GAP, which fixes the 3-cycle cadence.
  assign pop     = ((state_q == IDLE) || (state_q == GAP)) && !fifo_empty;
  // A slot freed by this edge's pop can take this edge's capture.
  assign push_ok = cap_vld & (~fifo_full | pop);
  assign drop    = cap_vld & fifo_full & ~pop;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push_ok),
    .push_dat (cap_rec),
    .pop      (pop),
    .head_dat (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = GAP;
      GAP:     state_d = pop ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    out_rec_d = pop ? head_rec : out_rec_q;

    // Registered strobe: high exactly for the cycle spent in STROBE.
    pulse_d = (state_q == SETUP);

    // Clear first, then a same-edge drop counts from zero.
    overflow_d = clear ? 1'b0 : overflow_q;
    drop_cnt_d = clear ? '0 : drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != CNT_MAX) drop_cnt_d = drop_cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      out_rec_q  <= '0;
      pulse_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_rec_q  <= out_rec_d;
      pulse_q    <= pulse_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_addr  = out_rec_q.addr;
  assign out_wdata = out_rec_q.wdata;
  assign out_rdata = out_rec_q.rdata;
  assign out_read  = out_rec_q.read;
  assign out_write = out_rec_q.write;
  assign out_pulse = pulse_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_dmem_trace_buffer.sv
// Self-checking bench for dmem_trace_buffer: directed scenarios plus random traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_trace_buffer;
  import dmem_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       cap_addr, cap_wdata, cap_rdata;
  logic              cap_read, cap_write, clear;
  logic [31:0]       out_addr, out_wdata, out_rdata;
  logic              out_read, out_write, out_pulse;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;

  always #5 clk = ~clk;

  dmem_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_addr  (cap_addr),
    .cap_wdata (cap_wdata),
    .cap_rdata (cap_rdata),
    .cap_read  (cap_read),
    .cap_write (cap_write),
    .clear     (clear),
    .out_addr  (out_addr),
    .out_wdata (out_wdata),
    .out_rdata (out_rdata),
    .out_read  (out_read),
    .out_write (out_write),
    .out_pulse (out_pulse),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending records and a "next load allowed" cycle.
  // A load in cycle c shows data from c+1, pulses in c+2, and the next load may happen in c+3 or later.
  trace_rec_t mq[$];
  trace_rec_t m_out;
  int         cyc;
  int         next_ok;
  int         pulse_cyc;
  int         m_drop;
  logic       m_ovf;
  logic       prev_pulse;

  function automatic bit pop_pred();
    return (mq.size() > 0) && (cyc >= next_ok);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out      = '0;
    next_ok    = 0;
    pulse_cyc  = -10;
    m_drop     = 0;
    m_ovf      = 1'b0;
    prev_pulse = 1'b0;
  endtask

  task automatic model_edge(input trace_rec_t r, input bit vld, input bit clr);
    if (pop_pred()) begin
      m_out     = mq.pop_front();
      next_ok   = cyc + 3;
      pulse_cyc = cyc + 2;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (vld) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else begin
        m_ovf = 1'b1;
        if (m_drop < (1 << CNT_W) - 1) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    chk("out_addr",  out_addr,  m_out.addr);
    chk("out_wdata", out_wdata, m_out.wdata);
    chk("out_rdata", out_rdata, m_out.rdata);
    chk("out_read",  out_read,  m_out.read);
    chk("out_write", out_write, m_out.write);
    chk("out_pulse", out_pulse, (cyc == pulse_cyc));
    chk("count",     count,     mq.size());
    chk("overflow",  overflow,  m_ovf);
    chk("drop_cnt",  drop_cnt,  m_drop);
    chk("pulse_iso", out_pulse & prev_pulse, 1'b0);
    prev_pulse = out_pulse;
  endtask

  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdt, input logic clr);
    trace_rec_t r;
    cap_read  = rd;
    cap_write = wr;
    cap_addr  = a;
    cap_wdata = wd;
    cap_rdata = rdt;
    clear     = clr;
    r = '{addr: a, wdata: wd, rdata: rdt, read: rd, write: wr};
    if (reset) model_edge(r, rd | wr, clr);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic push_rand(input logic clr);
    logic [1:0] f;
    f = 2'($urandom_range(1, 3));
    step(f[0], f[1], $urandom, $urandom, $urandom, clr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k, last;
    bit done;
    int d0;
    logic [1:0] f;

    reset = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_rdata = '0;
    cap_read = 1'b0; cap_write = 1'b0; clear = 1'b0;
    cyc = 0;
    model_reset();
    #1;
    chk("rst_pulse", out_pulse, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_addr",  out_addr, 32'h0);
    chk("rst_ovf",   overflow, 1'b0);
    chk("rst_drop",  drop_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Single write: latency of data and strobe.
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("t1_count_c1", count, 1);
    idle(1);
    chk("t1_addr_c2",  out_addr, 32'h10);
    chk("t1_wdata_c2", out_wdata, 32'hDEADBEEF);
    chk("t1_write_c2", out_write, 1'b1);
    chk("t1_read_c2",  out_read, 1'b0);
    chk("t1_pulse_c2", out_pulse, 1'b0);
    chk("t1_count_c2", count, 0);
    idle(1);
    chk("t1_pulse_c3", out_pulse, 1'b1);
    idle(1);
    chk("t1_pulse_c4", out_pulse, 1'b0);
    idle(3);

    // Four back-to-back reads: isolated pulses 3 cycles apart, in order.
    k = 0;
    last = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) step(1'b1, 1'b0, 32'(i * 4), 32'h0, 32'(i + 1), 1'b0);
      else idle(1);
      if (out_pulse) begin
        chk("t2_addr",  out_addr,  32'(k * 4));
        chk("t2_rdata", out_rdata, 32'(k + 1));
        if (k > 0) chk("t2_spacing", cyc - last, 3);
        last = cyc;
        k++;
      end
    end
    chk("t2_npulse", k, 4);

    // 12 consecutive captures, then a longer burst that must overflow.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'(i), 32'h0, 1'b0);
    idle(30);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'(i), ~32'(i), 1'b0);
    chk("burst_ovf", overflow, 1'b1);
    idle(30);

    // Full FIFO and a push on exactly the edge of a pop: accepted, no drop.
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (mq.size() == DEPTH && pop_pred()) begin
        d0 = m_drop;
        step(1'b1, 1'b0, 32'h300 + 32'(i), 32'h0, 32'(i), 1'b0);
        chk("fullpop_count", count, DEPTH);
        chk("fullpop_drop",  drop_cnt, d0);
        done = 1'b1;
      end else if (mq.size() == DEPTH) begin
        idle(1);
      end else begin
        step(1'b1, 1'b0, 32'h300 + 32'(i), 32'h0, 32'(i), 1'b0);
      end
    end
    chk("fullpop_reached", done, 1'b1);

    // Clear on the same edge as a drop while drop_cnt is 5.
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("clr_drop", drop_cnt, 0);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (m_drop == 5 && mq.size() == DEPTH && !pop_pred()) begin
        step(1'b0, 1'b1, 32'h400, 32'h5, 32'h0, 1'b1);
        chk("clrdrop_cnt", drop_cnt, 1);
        chk("clrdrop_ovf", overflow, 1'b1);
        done = 1'b1;
      end else begin
        step(1'b0, 1'b1, 32'h400 + 32'(i), 32'(i), 32'h0, 1'b0);
      end
    end
    chk("clrdrop_reached", done, 1'b1);

    // Reset asserted while out_pulse is high.
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (out_pulse) done = 1'b1;
      else idle(1);
    end
    chk("strobe_seen", done, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_pulse", out_pulse, 1'b0);
    chk("arst_count", count, 0);
    chk("arst_addr",  out_addr, 32'h0);
    chk("arst_ovf",   overflow, 1'b0);
    chk("arst_drop",  drop_cnt, 0);
    idle(2);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (out_pulse) k++;
    end
    chk("post_rst_pulses", k, 0);
    chk("post_rst_count", count, 0);

    // Random traffic at varying density, with occasional clears.
    for (int blk = 0; blk < 8; blk++) begin
      int thr;
      case (blk % 4)
        0: thr = 20;
        1: thr = 33;
        2: thr = 60;
        default: thr = 100;
      endcase
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 99) < thr) push_rand($urandom_range(0, 99) < 2);
        else begin
          f = 2'b00;
          step(f[0], f[1], $urandom, $urandom, $urandom, $urandom_range(0, 99) < 2);
        end
      end
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
